// File: rtl/photon_actuator_sequencer_if.sv
// photon_actuator_sequencer_if: sensor inputs, control and actuator/status outputs
// shared between the sequencer and its host.
interface photon_actuator_sequencer_if;
    logic [5:0] sens;
    logic       enable;
    logic       abort;
    logic [5:0] act;
    logic [2:0] active_id;
    logic       busy;
    logic [2:0] state;
    logic       fault;
    modport master (output sens, enable, abort, input act, active_id, busy, state, fault);
    modport slave  (input sens, enable, abort, output act, active_id, busy, state, fault);
endinterface

// File: rtl/photon_actuator_sequencer.sv
// photon_actuator_sequencer: synchronised, debounced photon sensors arbitrated round-robin
// onto one timed actuator slot (ARM -> FIRE dwell -> COOL).
module photon_actuator_sequencer #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int FIRE_CYC     = 8,
    parameter int COOL_CYC     = 4,
    parameter int CNT_W        = 8
) (
    input logic clk,
    input logic rst_n,
    photon_actuator_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE = 3'b000, ARM = 3'b001, FIRE = 3'b010, COOL = 3'b011} state_t;
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] FIRE_LAST = CNT_W'(FIRE_CYC - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOL_CYC - 1);

    state_t state, state_n;
    logic [5:0] s1, s2, deb, deb_d, rise, pend, pend_n, clr, rot, act_q, act_n;
    logic [CNT_W-1:0] dcnt [6];
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0] rr_ptr, ptr_n, id_q, id_n, f, g;
    logic [3:0] sum;
    logic fault_q, fault_n, grant, take;

    assign rise = deb & ~deb_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            deb <= '0;
            deb_d <= '0;
            for (int i = 0; i < 6; i++) dcnt[i] <= '0;
        end else begin
            s1 <= bus.sens;
            s2 <= s1;
            deb_d <= deb;
            for (int i = 0; i < 6; i++) begin
                if (s2[i] == deb[i]) dcnt[i] <= '0;
                else if (dcnt[i] == DEB_LAST) begin
                    dcnt[i] <= '0;
                    deb[i] <= ~deb[i];
                end else dcnt[i] <= dcnt[i] + 1'b1;
            end
        end
    end

    // Rotate pend so the search always starts at bit 0, then map back to a channel index.
    always_comb begin
        rot = 6'({pend, pend} >> rr_ptr);
        f = '0;
        for (int k = 5; k >= 0; k--) if (rot[k]) f = 3'(k);
        sum = {1'b0, rr_ptr} + {1'b0, f};
        g = (sum >= 4'd6) ? 3'(sum - 4'd6) : sum[2:0];
    end

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        id_n = id_q;
        ptr_n = rr_ptr;
        clr = '0;
        fault_n = fault_q;
        take = 1'b0;
        grant = bus.enable && (|pend);
        case (state)
            IDLE: take = grant;
            ARM:  state_n = FIRE;
            FIRE: begin
                cnt_n = (cnt == FIRE_LAST) ? '0 : cnt + 1'b1;
                state_n = (cnt == FIRE_LAST) ? COOL : FIRE;
            end
            COOL: begin
                cnt_n = (cnt == COOL_LAST) ? '0 : cnt + 1'b1;
                state_n = (cnt == COOL_LAST) ? IDLE : COOL;
                id_n = (cnt == COOL_LAST) ? 3'd0 : id_q;
                take = grant && (cnt == COOL_LAST);
            end
            default: state_n = IDLE;
        endcase
        if (take) begin
            state_n = ARM;
            id_n = g + 3'd1;
            ptr_n = (g == 3'd5) ? 3'd0 : g + 3'd1;
            clr = 6'd1 << g;
        end
        if (bus.abort && state != IDLE) begin
            state_n = IDLE;
            cnt_n = '0;
            id_n = '0;
            ptr_n = rr_ptr;
            clr = '0;
            fault_n = 1'b1;
        end else if (state == IDLE && !bus.enable) fault_n = 1'b0;
        // A fresh rise wins over a same-cycle grant clear so the re-request stays queued.
        pend_n = (pend & ~clr) | rise;
        act_n = (state_n == FIRE) ? 6'd1 << (id_n - 3'd1) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            rr_ptr <= '0;
            pend <= '0;
            act_q <= '0;
            id_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            rr_ptr <= ptr_n;
            pend <= pend_n;
            act_q <= act_n;
            id_q <= id_n;
            fault_q <= fault_n;
        end
    end

    assign bus.act = act_q;
    assign bus.active_id = id_q;
    assign bus.busy = (state != IDLE);
    assign bus.state = state;
    assign bus.fault = fault_q;
endmodule

// File: tb/tb_photon_actuator_sequencer.sv
// tb_photon_actuator_sequencer: directed scenarios plus randomized traffic against a
// timeline-based reference model of the sequencer.
module tb_photon_actuator_sequencer;
    localparam int DEB = 4, FC = 8, CC = 4, LAST = FC + CC;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0, n_err = 0;

    photon_actuator_sequencer_if ifc ();
    photon_actuator_sequencer #(.DEBOUNCE_CYC(DEB), .FIRE_CYC(FC), .COOL_CYC(CC), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc));

    always #5 clk = ~clk;

    // Reference: sensors as delayed samples with stable-run counts, sequence as a position
    // on a timeline since the grant (0 = ARM, 1..FC = FIRE, FC+1..LAST = COOL, -1 = idle).
    logic [5:0] m_s1, m_s2, m_deb, m_rose, m_pend;
    int m_run [6];
    int m_pos, m_cur, m_ptr;
    logic m_fault;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_rose = '0; m_pend = '0;
        for (int i = 0; i < 6; i++) m_run[i] = 0;
        m_pos = -1; m_cur = -1; m_ptr = 0; m_fault = 1'b0;
    endtask

    task automatic model_step();
        logic [5:0] clr, rose_n;
        int g, c;
        if (!rst_n) begin
            model_reset();
            return;
        end
        clr = '0;
        if (m_pos >= 0 && ifc.abort) begin
            m_pos = -1; m_cur = -1; m_fault = 1'b1;
        end else begin
            if (m_pos < 0 && !ifc.enable) m_fault = 1'b0;
            if (ifc.enable && (|m_pend) && (m_pos < 0 || m_pos == LAST)) begin
                g = -1;
                for (int k = 0; k < 6; k++) begin
                    c = (m_ptr + k) % 6;
                    if (g < 0 && m_pend[c[2:0]]) g = c;
                end
                m_pos = 0; m_cur = g; m_ptr = (g + 1) % 6; clr[g[2:0]] = 1'b1;
            end else if (m_pos == LAST) begin
                m_pos = -1; m_cur = -1;
            end else if (m_pos >= 0) m_pos++;
        end
        m_pend = (m_pend & ~clr) | m_rose;
        rose_n = '0;
        for (int i = 0; i < 6; i++) begin
            if (m_s2[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_deb[i] = ~m_deb[i];
                    m_run[i] = 0;
                    rose_n[i] = m_deb[i];
                end
            end else m_run[i] = 0;
        end
        m_rose = rose_n;
        m_s2 = m_s1;
        m_s1 = ifc.sens;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        ifc.sens = '0; ifc.enable = 1'b0; ifc.abort = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({ifc.act, ifc.active_id, ifc.busy, ifc.state, ifc.fault, dut.pend} !== 20'd0) begin
            n_err++;
            $display("FAIL reset: act=%b id=%0d busy=%b state=%0d fault=%b pend=%b, want all 0",
                     ifc.act, ifc.active_id, ifc.busy, ifc.state, ifc.fault, dut.pend);
        end
        ifc.enable = 1'b1;
        repeat (5) tick();
        n_cmp++;
        if ({ifc.act, ifc.busy, ifc.state} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_idle: act=%b busy=%b state=%0d, want 0/0/0", ifc.act, ifc.busy, ifc.state);
        end
    endtask

    task automatic test_single();
        logic [2:0] es, ei;
        logic [5:0] ea;
        apply_reset();
        ifc.enable = 1'b1;
        ifc.sens = 6'b000100;
        for (int e = 1; e <= 22; e++) begin
            tick();
            es = (e < 8) ? 3'd0 : (e == 8) ? 3'd1 : (e <= 16) ? 3'd2 : (e <= 20) ? 3'd3 : 3'd0;
            ea = (e >= 9 && e <= 16) ? 6'b000100 : 6'b0;
            ei = (e >= 8 && e <= 20) ? 3'd3 : 3'd0;
            n_cmp++;
            if ({ifc.state, ifc.act, ifc.active_id} !== {es, ea, ei}) begin
                n_err++;
                $display("FAIL single edge %0d: state=%0d act=%b id=%0d, want state=%0d act=%b id=%0d",
                         e, ifc.state, ifc.act, ifc.active_id, es, ea, ei);
            end
        end
    endtask

    task automatic test_glitch();
        apply_reset();
        ifc.enable = 1'b1;
        ifc.sens = 6'b000001;
        repeat (3) tick();
        ifc.sens = '0;
        for (int e = 0; e < 16; e++) begin
            tick();
            n_cmp++;
            if ({ifc.state, ifc.act} !== 9'd0) begin
                n_err++;
                $display("FAIL glitch cyc %0d: state=%0d act=%b, want 0/0", e, ifc.state, ifc.act);
            end
        end
        n_cmp++;
        if (dut.pend !== 6'd0) begin
            n_err++;
            $display("FAIL glitch_pend: pend=%b, want 000000", dut.pend);
        end
    endtask

    task automatic test_round_robin();
        int got[$];
        int exp_rr[5] = '{1, 4, 6, 1, 4};
        int gaps = 0;
        apply_reset();
        ifc.enable = 1'b1;
        ifc.sens = 6'b101001;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (ifc.state == 3'd1) got.push_back(int'(ifc.active_id));
            if ((got.size() == 1 || got.size() == 2) && ifc.state == 3'd0) gaps++;
        end
        ifc.sens = '0;
        repeat (12) tick();
        ifc.sens = 6'b001001;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (ifc.state == 3'd1) got.push_back(int'(ifc.active_id));
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (i >= got.size() || got[i] != exp_rr[i]) begin
                n_err++;
                $display("FAIL rr_grant %0d: got id=%0d, want %0d", i, (i < got.size()) ? got[i] : -1, exp_rr[i]);
            end
        end
        n_cmp++;
        if (gaps != 0 || got.size() != 5) begin
            n_err++;
            $display("FAIL rr_b2b: idle cycles between grants=%0d grants=%0d, want 0 and 5", gaps, got.size());
        end
    endtask

    task automatic test_abort();
        apply_reset();
        ifc.enable = 1'b1;
        ifc.sens = 6'b000011;
        repeat (11) tick();
        n_cmp++;
        if ({ifc.state, ifc.act, ifc.active_id} !== {3'd2, 6'b000001, 3'd1}) begin
            n_err++;
            $display("FAIL abort_pre: state=%0d act=%b id=%0d, want 2/000001/1", ifc.state, ifc.act, ifc.active_id);
        end
        ifc.abort = 1'b1;
        tick();
        ifc.abort = 1'b0;
        ifc.enable = 1'b0;
        n_cmp++;
        if ({ifc.state, ifc.act, ifc.active_id, ifc.fault} !== {3'd0, 6'd0, 3'd0, 1'b1}) begin
            n_err++;
            $display("FAIL abort: state=%0d act=%b id=%0d fault=%b, want 0/000000/0/1",
                     ifc.state, ifc.act, ifc.active_id, ifc.fault);
        end
        tick();
        n_cmp++;
        if ({ifc.state, ifc.fault} !== 4'd0) begin
            n_err++;
            $display("FAIL abort_clear: state=%0d fault=%b, want 0/0", ifc.state, ifc.fault);
        end
        ifc.enable = 1'b1;
        tick();
        n_cmp++;
        if ({ifc.state, ifc.active_id} !== {3'd1, 3'd2}) begin
            n_err++;
            $display("FAIL abort_pend_kept: state=%0d id=%0d, want 1/2", ifc.state, ifc.active_id);
        end
    endtask

    task automatic test_enable();
        apply_reset();
        ifc.sens = 6'b010000;
        for (int e = 0; e < 15; e++) begin
            tick();
            n_cmp++;
            if ({ifc.state, ifc.busy} !== 4'd0) begin
                n_err++;
                $display("FAIL enable_gate cyc %0d: state=%0d busy=%b, want 0/0", e, ifc.state, ifc.busy);
            end
        end
        ifc.enable = 1'b1;
        tick();
        n_cmp++;
        if ({ifc.state, ifc.active_id, ifc.busy} !== {3'd1, 3'd5, 1'b1}) begin
            n_err++;
            $display("FAIL enable_rise: state=%0d id=%0d busy=%b, want 1/5/1", ifc.state, ifc.active_id, ifc.busy);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        ifc.enable = 1'b1;
        ifc.sens = 6'b000100;
        repeat (10) tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({ifc.act, ifc.state, ifc.busy, dut.pend} !== 16'd0) begin
            n_err++;
            $display("FAIL async_reset: act=%b state=%0d busy=%b pend=%b, want all 0",
                     ifc.act, ifc.state, ifc.busy, dut.pend);
        end
        #1 rst_n = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            n_cmp++;
            if (ifc.act !== ((e == 9) ? 6'b000100 : 6'b0) || ifc.state !== ((e < 8) ? 3'd0 : (e == 8) ? 3'd1 : 3'd2)) begin
                n_err++;
                $display("FAIL async_redebounce edge %0d: act=%b state=%0d", e, ifc.act, ifc.state);
            end
        end
    endtask

    task automatic test_random();
        logic [13:0] got_v, exp_v;
        logic [2:0] ms;
        apply_reset();
        ifc.enable = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 6; i++) if ($urandom_range(0, 19) == 0) ifc.sens[i] = ~ifc.sens[i];
            if ($urandom_range(0, 49) == 0) ifc.enable = ~ifc.enable;
            ifc.abort = ($urandom_range(0, 79) == 0);
            tick();
            ms = (m_pos < 0) ? 3'd0 : (m_pos == 0) ? 3'd1 : (m_pos <= FC) ? 3'd2 : 3'd3;
            exp_v = {ms, (m_pos >= 1 && m_pos <= FC) ? 6'd1 << m_cur : 6'd0,
                     (m_pos < 0) ? 3'd0 : 3'(m_cur + 1), m_pos >= 0, m_fault};
            got_v = {ifc.state, ifc.act, ifc.active_id, ifc.busy, ifc.fault};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL random cyc %0d: got st/act/id/busy/flt=%b, want %b", c, got_v, exp_v);
            end
        end
        ifc.abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_round_robin();
        test_abort();
        test_enable();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
